// File: rtl/es_pkg.sv
// es_pkg: shared widths and FSM state encoding for the IO controller
package es_pkg;
   localparam int IO_WIDTH = 32;
   localparam int SW_WIDTH = 10;
   typedef enum logic [1:0] {IDLE, ARMED, WAIT_PRESS, DONE} state_t;
endpackage

// File: rtl/filtro_botao.sv
// filtro_botao: push-button synchronizer with counter debouncer under CONTROLADOR_ES_DEBOUNCE_EN
module filtro_botao #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_n,
   output logic pressed
);
   logic s1, s2;
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_range
      $error("DEBOUNCE_CYCLES out of range");
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) {s1, s2} <= 2'b11;
      else {s1, s2} <= {raw_n, s1};
`ifdef CONTROLADOR_ES_DEBOUNCE_EN
   logic [15:0] cnt;
   logic lvl;
   assign lvl = ~s2;
   // counter only runs while the level disagrees and resets on the flip, so it tops out at DEBOUNCE_CYCLES-1
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         cnt     <= '0;
         pressed <= 1'b0;
      end else if (lvl == pressed) cnt <= '0;
      else if (cnt >= 16'(DEBOUNCE_CYCLES - 1)) begin
         pressed <= lvl;
         cnt     <= '0;
      end else cnt <= cnt + 16'd1;
`else
   assign pressed = ~s2;
`endif
endmodule

// File: rtl/controlador_es.sv
// controlador_es: processor IO controller (button-confirmed input, display output); debounce via CONTROLADOR_ES_DEBOUNCE_EN
module controlador_es
   import es_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_req,
   input  logic                out_req,
   input  logic [IO_WIDTH-1:0] wr_data,
   input  logic [SW_WIDTH-1:0] switches,
   input  logic                confirm,
   output logic [IO_WIDTH-1:0] rd_data,
   output logic                stall,
   output logic [IO_WIDTH-1:0] disp_value,
   output logic                disp_valid
);
   state_t state_q, state_d;
   logic btn_pressed, capture, disp_load;
   logic [SW_WIDTH-1:0] sw_s1, sw_s2;
   filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro (
      .clock  (clock),
      .reset  (reset),
      .raw_n  (confirm),
      .pressed(btn_pressed)
   );
   always_ff @(posedge clock or negedge reset)
      if (!reset) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:       state_d = in_req ? ARMED : IDLE;
         ARMED:      state_d = !in_req ? IDLE : (!btn_pressed ? WAIT_PRESS : ARMED);
         WAIT_PRESS: state_d = !in_req ? IDLE : (btn_pressed ? DONE : WAIT_PRESS);
         default:    state_d = IDLE;
      endcase
   end
   always_comb begin
      stall     = in_req & (state_q != DONE);
      capture   = in_req & btn_pressed & (state_q == WAIT_PRESS);
      disp_load = out_req & ~in_req;
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         sw_s1      <= '0;
         sw_s2      <= '0;
         rd_data    <= '0;
         disp_value <= '0;
         disp_valid <= 1'b0;
      end else begin
         sw_s1      <= switches;
         sw_s2      <= sw_s1;
         rd_data    <= capture ? {{(IO_WIDTH-SW_WIDTH){1'b0}}, sw_s2} : rd_data;
         disp_value <= disp_load ? wr_data : disp_value;
         disp_valid <= disp_load;
      end
endmodule

// File: tb/tb_controlador_es.sv
// tb_controlador_es: scoreboard bench for controlador_es with DEBOUNCE_CYCLES=4
module tb_controlador_es;
   import es_pkg::*;
`ifdef CONTROLADOR_ES_DEBOUNCE_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif
   logic clock, reset, in_req, out_req, confirm, stall, disp_valid;
   logic [31:0] wr_data, rd_data, disp_value;
   logic [9:0] switches;
   typedef struct {bit is_rd; logic [31:0] val;} exp_t;
   exp_t q[$];
   int total = 0, bad = 0;
   controlador_es #(.DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .in_req(in_req), .out_req(out_req),
      .wr_data(wr_data), .switches(switches), .confirm(confirm),
      .rd_data(rd_data), .stall(stall), .disp_value(disp_value), .disp_valid(disp_valid)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic mon_pop(input bit is_rd, input logic [31:0] act, input string name);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s_unexpected: got %h expected none", name, act);
      end else begin
         e = q.pop_front();
         chk({name, "_kind"}, 32'(is_rd), 32'(e.is_rd));
         chk({name, "_val"}, act, e.val);
      end
   endtask
   always @(negedge clock)
      if (reset) begin
         if (disp_valid) mon_pop(1'b0, disp_value, "disp");
         if (in_req && !stall) mon_pop(1'b1, rd_data, "rd");
      end
   task automatic wait_done(input string name);
      int cyc = 0;
      for (int i = 1; i <= 60; i++) begin
         tick(1);
         if (!stall) begin
            cyc = i;
            break;
         end
      end
      chk(name, 32'(cyc), 32'(LAT));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      bit saw_done, saw_btn;
      reset = 0; in_req = 0; out_req = 0; wr_data = 0; switches = 0; confirm = 1;
      #1;
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("rst_rd", rd_data, 0);
      chk("rst_disp", disp_value, 0);
      chk("rst_valid", 32'(disp_valid), 0);
      chk("rst_stall", 32'(stall), 0);
      tick(2);
      reset = 1;
      // basic read, then back-to-back request with the button still held
      switches = 10'h2A5;
      tick(3);
      in_req = 1;
      #1;
      chk("idle_req_stall", 32'(stall), 1);
      tick(1);
      chk("armed", 32'(dut.state_q), 32'(ARMED));
      tick(1);
      chk("wait_press", 32'(dut.state_q), 32'(WAIT_PRESS));
      q.push_back('{1'b1, 32'h0000_02A5});
      confirm = 0;
      wait_done("press_latency");
      tick(1);
      chk("b2b_stall", 32'(stall), 1);
      chk("b2b_idle", 32'(dut.state_q), 32'(IDLE));
      tick(1);
      chk("b2b_armed_held", 32'(dut.state_q), 32'(ARMED));
      in_req = 0; confirm = 1;
      tick(12);
      // button held before the request
      switches = 10'h155;
      confirm = 0;
      tick(12);
      in_req = 1;
      tick(6);
      chk("held_armed", 32'(dut.state_q), 32'(ARMED));
      chk("held_stall", 32'(stall), 1);
      chk("held_rd_kept", rd_data, 32'h2A5);
      confirm = 1;
      tick(12);
      q.push_back('{1'b1, 32'h0000_0155});
      confirm = 0;
      wait_done("held_latency");
      tick(1);
      in_req = 0; confirm = 1;
      tick(12);
`ifdef CONTROLADOR_ES_DEBOUNCE_EN
      switches = 10'h3FF;
      in_req = 1;
      tick(2);
      saw_done = 0; saw_btn = 0;
      for (int i = 0; i < 10; i++) begin
         confirm = ~confirm;
         repeat (2) begin
            tick(1);
            saw_done |= !stall;
            saw_btn  |= dut.btn_pressed;
         end
      end
      chk("bounce_no_done", 32'(saw_done), 0);
      chk("bounce_no_btn", 32'(saw_btn), 0);
      confirm = 1; in_req = 0;
      tick(1);
      chk("bounce_idle", 32'(dut.state_q), 32'(IDLE));
      chk("bounce_rd_kept", rd_data, 32'h155);
      tick(10);
`endif
      // display write
      out_req = 1; wr_data = 32'hDEADBEEF;
      q.push_back('{1'b0, 32'hDEADBEEF});
      #1;
      chk("out_stall", 32'(stall), 0);
      tick(1);
      out_req = 0;
      chk("out_value", disp_value, 32'hDEADBEEF);
      chk("out_valid", 32'(disp_valid), 1);
      tick(1);
      chk("out_valid_drop", 32'(disp_valid), 0);
      // in_req wins over out_req
      in_req = 1; out_req = 1; wr_data = 32'h12345678;
      #1;
      chk("conf_stall", 32'(stall), 1);
      tick(1);
      chk("conf_valid", 32'(disp_valid), 0);
      chk("conf_value", disp_value, 32'hDEADBEEF);
      in_req = 0; out_req = 0;
      tick(3);
      // reset while waiting for the press
      in_req = 1;
      tick(2);
      chk("pre_rst_wait", 32'(dut.state_q), 32'(WAIT_PRESS));
      reset = 0;
      #1;
      chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("mid_rst_rd", rd_data, 0);
      chk("mid_rst_disp", disp_value, 0);
      tick(1);
      reset = 1;
      tick(1);
      chk("post_rst_armed", 32'(dut.state_q), 32'(ARMED));
      chk("post_rst_stall", 32'(stall), 1);
      in_req = 0;
      tick(2);
      chk("queue_empty", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
